rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The module SHALL take parameter ADDR_LENGTH, default 8, giving the word-address width of the target memory (256 words, 1 KB).
REQ-002 The module SHALL take parameter MEM_SIZE, default 2**ADDR_LENGTH, giving the target memory depth in 32-bit words.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a load session.
REQ-006 length_words  input  ADDR_LENGTH+1  number of 32-bit words to load; sampled on an accepted start.
REQ-007 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-008 in_data  input  8  byte-stream payload.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 we  output  1  memory write strobe, one cycle per word.
REQ-011 waddr  output  32  memory byte address (word-aligned; bits [1:0] and [31:ADDR_LENGTH+2] always 0).
REQ-012 wdata  output  32  memory write data.
REQ-013 busy  output  1  session in progress.
REQ-014 done  output  1  sticky session-complete flag.
REQ-015 error  output  1  sticky flag: length_words exceeded MEM_SIZE.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, WRITE, DONE.
REQ-017 start SHALL be accepted only in IDLE or DONE; start in LOAD or WRITE SHALL be ignored.
REQ-018 On accepted start: clear done/error, word index=0, byte index=0, latch length_words.
REQ-019 Accepted start with length_words==0 SHALL go to DONE next cycle with no writes.
REQ-020 Accepted start with length_words>MEM_SIZE SHALL set error and go to DONE with no writes.
REQ-021 Otherwise accepted start SHALL enter LOAD next cycle.
REQ-022 in_ready SHALL be 1 only in LOAD; a byte is transferred when in_valid && in_ready.
REQ-023 Byte k (0..3) of a word SHALL land in wdata bits [8k+7:8k] (little-endian).
REQ-024 Transfer of byte 3 in cycle N SHALL move to WRITE, with we=1 in cycle N+1 only.
REQ-025 In WRITE, waddr SHALL equal word_index*4 and wdata the assembled word; in_ready=0.
REQ-026 After WRITE: word_index+1 == latched length -> DONE; else word_index increments and LOAD.
REQ-027 Peak throughput SHALL be one word per 5 cycles; in_valid gaps SHALL stall without loss.
REQ-028 busy SHALL be 1 in LOAD and WRITE, else 0.
REQ-029 done SHALL be 1 in DONE and remain 1 until the next accepted start or reset.
REQ-030 we SHALL be 0 in every state except WRITE.
REQ-031 Word index SHALL never exceed MEM_SIZE-1; length==MEM_SIZE writes the last word at waddr=(MEM_SIZE-1)*4 with no wrap.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE and in_ready, we, busy, done, error to 0, waddr and wdata to 0.
REQ-033 Reset during LOAD or WRITE SHALL discard the partial word; no write issued after rst_n deasserts until a new start.
REQ-034 After rst_n rises, the block SHALL stay in IDLE until start.

Verification
REQ-035 start, length=1, bytes 0x13,0x00,0x00,0x00 back-to-back -> single we pulse 1 cycle after 4th byte, waddr=0x0, wdata=0x00000013, done=1 next cycle.
REQ-036 length=3, 12 bytes with random in_valid gaps -> we pulses at waddr 0x0,0x4,0x8 with correct little-endian words, exactly 3 pulses, busy low only after third.
REQ-037 length=0 -> done=1 next cycle, we never asserted; length=257 (ADDR_LENGTH=8) -> error=1, done=1, no writes.
REQ-038 length=256 full stream -> last write waddr=0x3FC, then DONE; start pulsed mid-load ignored (no restart, word count unchanged).
REQ-039 rst_n pulled low after 2 bytes of word 1 -> outputs zero asynchronously; after release and new start, first write at waddr=0x0 with only new bytes.
REQ-040 start while done=1 -> done clears next cycle, new session loads from waddr=0x0.

Source files
------------

// File: rtl/rom_loader.sv
// Byte-stream to word-memory loader: assembles little-endian 32-bit words from an
// 8-bit valid/ready stream and issues one write strobe per word to a target memory.
module rom_loader #(
  parameter int ADDR_LENGTH = 8,
  parameter int MEM_SIZE    = 2 ** ADDR_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_LENGTH:0]   length_words,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   we,
  output logic [31:0]            waddr,
  output logic [31:0]            wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int LEN_W = ADDR_LENGTH + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                 state;
  logic [ADDR_LENGTH-1:0] word_idx;
  logic [1:0]             byte_idx;
  logic [LEN_W-1:0]       len_q;
  logic [23:0]            byte_buf;
  logic [LEN_W-1:0]       word_count;

  // Words completed once the word currently in WRITE has been issued.
  assign word_count = {1'b0, word_idx} + LEN_W'(1);

  // NOTE: state lives in always_ff with non-blocking (<=) assignments so every
  // register samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_idx <= '0;
      byte_idx <= '0;
      len_q    <= '0;
      byte_buf <= '0;
      in_ready <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done     <= 1'b0;
            error    <= 1'b0;
            word_idx <= '0;
            byte_idx <= '0;
            len_q    <= length_words;
            if (length_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (length_words > LEN_W'(MEM_SIZE)) begin
              state <= DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // The fourth byte goes straight to wdata; only bytes 0..2 are buffered.
              state    <= WRITE;
              in_ready <= 1'b0;
              we       <= 1'b1;
              waddr    <= 32'(word_idx) << 2;
              wdata    <= {in_data, byte_buf};
            end else begin
              byte_buf[8*byte_idx +: 8] <= in_data;
            end
          end
        end
        WRITE: begin
          if (word_count == len_q) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            word_idx <= word_idx + ADDR_LENGTH'(1);
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: random words streamed byte by byte, writes
// captured by a monitor and compared against words built arithmetically from the stream.
module tb_rom_loader;

  localparam int AL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [AL:0] length_words = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  logic [63:0] obs_q[$];

  rom_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .length_words (length_words),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Write monitor: one entry per cycle with the strobe high.
  always @(negedge clk) if (rst_n && we) obs_q.push_back({waddr, wdata});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int len);
    start        = 1'b1;
    length_words = len[AL:0];
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n = 0;
    repeat ($urandom_range(0, max_gap)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("ready_timeout", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_session(input int len, input int max_gap, input int mid_start_word);
    logic [31:0] exp_words[$];
    int          n_obs;
    obs_q.delete();
    for (int i = 0; i < len; i++) exp_words.push_back($urandom);
    do_start(len);
    check("start_busy", busy, 1'b1);
    check("start_ready", in_ready, 1'b1);
    check("start_done_clr", done, 1'b0);
    check("start_err_clr", error, 1'b0);
    for (int w = 0; w < len; w++) begin
      if (w == mid_start_word) begin
        do_start(1);
        check("mid_start_ignored", busy, 1'b1);
      end
      for (int k = 0; k < 4; k++) send_byte(8'(exp_words[w] >> (8 * k)), max_gap);
      check("we_after_byte3", we, 1'b1);
      check("busy_in_write", busy, 1'b1);
    end
    @(negedge clk);
    check("end_done", done, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_we", we, 1'b0);
    check("end_error", error, 1'b0);
    n_obs = obs_q.size();
    check("write_count", n_obs, len);
    for (int i = 0; i < len && i < n_obs; i++) begin
      check("waddr", obs_q[i][63:32], 32'(i * 4));
      check("wdata", obs_q[i][31:0], exp_words[i]);
    end
  endtask

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_waddr", waddr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_ready", in_ready, 1'b0);

    // Single word, back-to-back bytes: strobe in the cycle after byte 3, done the next.
    obs_q.delete();
    do_start(1);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("w1_we", we, 1'b1);
    check("w1_waddr", waddr, 32'h0);
    check("w1_wdata", wdata, 32'h13);
    check("w1_done_early", done, 1'b0);
    @(negedge clk);
    check("w1_we_drop", we, 1'b0);
    check("w1_done", done, 1'b1);
    check("w1_count", obs_q.size(), 1);

    // Three words with random valid gaps (start while done=1 also clears done).
    run_session(3, 3, -1);

    // Zero-length and oversize requests complete immediately with no writes.
    obs_q.delete();
    do_start(0);
    check("len0_done", done, 1'b1);
    check("len0_busy", busy, 1'b0);
    check("len0_error", error, 1'b0);
    repeat (4) @(negedge clk);
    check("len0_no_write", obs_q.size(), 0);
    do_start(257);
    check("len257_error", error, 1'b1);
    check("len257_done", done, 1'b1);
    check("len257_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    check("len257_no_write", obs_q.size(), 0);

    // Full memory, with a start pulse in the middle that must be ignored.
    run_session(256, 0, 100);

    // Reset mid-word: outputs drop asynchronously, partial bytes are discarded.
    obs_q.delete();
    do_start(2);
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    check("pre_rst_ready", in_ready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", in_ready, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_we", we, 1'b0);
    check("arst_waddr", waddr, 32'h0);
    check("arst_wdata", wdata, 32'h0);
    check("arst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_writes", obs_q.size(), 1);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_ready", in_ready, 1'b0);
    run_session(1, 1, -1);

    for (int s = 0; s < 4; s++) run_session(int'($urandom_range(1, 6)), 2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
